// File: rtl/rf_pkg.sv
// Shared types for the register-file writeback path: address/data widths and the
// writeback request payload carried through the multi-cycle result FIFO.
package rf_pkg;

    localparam int unsigned NUM_REGS = 32;

    typedef logic [4:0]  reg_addr_t;
    typedef logic [31:0] data_t;

    typedef struct packed {
        reg_addr_t addr;
        data_t     data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo2.sv
// Two-entry valid/ready FIFO holding multi-cycle writeback results.
// Synchronous active-high reset empties it; in_ready_o is held low during reset.
module wb_fifo2
    import rf_pkg::*;
(
    input  logic    clk_i,
    input  logic    rst_i,
    input  logic    in_valid_i,
    output logic    in_ready_o,
    input  wb_req_t in_data_i,
    output logic    out_valid_o,
    input  logic    out_ready_i,
    output wb_req_t out_data_o
);

    logic [1:0] count_q, count_d;
    logic       wr_ptr_q, rd_ptr_q;
    wb_req_t    mem_q [2];
    logic       in_fire, out_fire;

    always_comb begin
        in_ready_o  = (count_q != 2'd2) && !rst_i;
        out_valid_o = (count_q != 2'd0);
        out_data_o  = mem_q[rd_ptr_q];
        in_fire     = in_valid_i && in_ready_o;
        out_fire    = out_valid_o && out_ready_i;
        count_d     = count_q + 2'(in_fire) - 2'(out_fire);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            count_q <= count_d;
            if (in_fire) begin
                wr_ptr_q <= ~wr_ptr_q;
            end
            if (out_fire) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    // Payload storage needs no reset: entries are only read while counted valid.
    always_ff @(posedge clk_i) begin
        if (in_fire) begin
            mem_q[wr_ptr_q] <= in_data_i;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write port arbiter: main pipeline has priority, multi-cycle results queue
// in wb_fifo2, and a busy scoreboard drives decode stall. WB_STARVE_GUARD_EN enables hold.
module regfile_wb_arbiter
    import rf_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_waddr,
    input  logic [31:0] pipe_wdata,
    input  logic        mc_valid,
    output logic        mc_ready,
    input  logic [4:0]  mc_waddr,
    input  logic [31:0] mc_wdata,
    input  logic        issue_valid,
    input  logic [4:0]  issue_rd,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    output logic        stall,
    output logic        pipe_hold,
    output logic        RegWrite,
    output logic [4:0]  waddr,
    output logic [31:0] wdata
);

    wb_req_t              mc_req, head;
    logic                 head_valid, head_fire;
    logic                 pipe_req, pipe_win, hold;
    logic [NUM_REGS-1:0]  busy_q, busy_d;

    assign mc_req = '{addr: mc_waddr, data: mc_wdata};

    wb_fifo2 u_fifo (
        .clk_i       (Clk),
        .rst_i       (Reset),
        .in_valid_i  (mc_valid),
        .in_ready_o  (mc_ready),
        .in_data_i   (mc_req),
        .out_valid_o (head_valid),
        .out_ready_i (head_fire),
        .out_data_o  (head)
    );

    assign pipe_req = pipe_we && (pipe_waddr != 5'd0);

`ifdef WB_STARVE_GUARD_EN
    localparam int unsigned CntW = $clog2(STARVE_MAX + 1);

    logic [CntW-1:0] starve_q, starve_d;

    assign hold = head_valid && (starve_q == CntW'(STARVE_MAX)) && !Reset;

    always_comb begin
        starve_d = '0;
        if (head_valid && !head_fire) begin
            starve_d = starve_q + CntW'(1);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end
`else
    // Guard compiled out: STARVE_MAX has no effect and the pipeline is never held.
    assign hold = (STARVE_MAX > 0) & 1'b0;
`endif

    assign pipe_win  = pipe_req && !hold;
    assign head_fire = head_valid && !pipe_win && !Reset;
    assign pipe_hold = hold;

    always_comb begin
        RegWrite = 1'b0;
        waddr    = pipe_waddr;
        wdata    = pipe_wdata;
        if (!Reset) begin
            if (pipe_win) begin
                RegWrite = 1'b1;
            end else if (head_valid) begin
                RegWrite = 1'b1;
                waddr    = head.addr;
                wdata    = head.data;
            end
        end
    end

    // Clear applies first so a same-cycle issue to the written register keeps it busy.
    always_comb begin
        busy_d = busy_q;
        if (head_fire) begin
            busy_d[head.addr] = 1'b0;
        end
        if (issue_valid && (issue_rd != 5'd0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign stall = !Reset && (busy_q[id_rs1] || busy_q[id_rs2] || busy_q[id_rd]);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: per-cycle vector table plus hand sequences;
// every register-file write is checked against an expected-write queue.
module tb_regfile_wb_arbiter;
    import rf_pkg::*;

    logic        Clk, Reset;
    logic        pipe_we, mc_valid, issue_valid;
    logic [4:0]  pipe_waddr, mc_waddr, issue_rd, id_rs1, id_rs2, id_rd;
    logic [31:0] pipe_wdata, mc_wdata;
    logic        mc_ready, stall, pipe_hold, RegWrite;
    logic [4:0]  waddr;
    logic [31:0] wdata;

    int n_checks = 0;
    int n_errors = 0;

    wb_req_t exp_q [$];

    typedef struct {
        logic        pwe;
        logic [4:0]  pwa;
        logic [31:0] pwd;
        logic        mcv;
        logic [4:0]  mca;
        logic [31:0] mcd;
        logic        iv;
        logic [4:0]  ird;
        logic [4:0]  rs1, rs2, rd;
        logic        e_rw;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic        e_rdy;
        logic        e_stall;
    } vec_t;

    vec_t vecs [$];

    regfile_wb_arbiter #(.STARVE_MAX(4)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .pipe_we     (pipe_we),
        .pipe_waddr  (pipe_waddr),
        .pipe_wdata  (pipe_wdata),
        .mc_valid    (mc_valid),
        .mc_ready    (mc_ready),
        .mc_waddr    (mc_waddr),
        .mc_wdata    (mc_wdata),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_rd       (id_rd),
        .stall       (stall),
        .pipe_hold   (pipe_hold),
        .RegWrite    (RegWrite),
        .waddr       (waddr),
        .wdata       (wdata)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Write monitor: every non-reset write must match the oldest expected write.
    always @(negedge Clk) begin
        if (RegWrite === 1'b1 && Reset === 1'b0) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_write: got x%0d=%0h expected no write", waddr, wdata);
            end else begin
                wb_req_t e;
                e = exp_q.pop_front();
                check("write_addr", 32'(waddr), 32'(e.addr));
                check("write_data", wdata, e.data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    task automatic idle_inputs();
        pipe_we = 0; pipe_waddr = 0; pipe_wdata = 0;
        mc_valid = 0; mc_waddr = 0; mc_wdata = 0;
        issue_valid = 0; issue_rd = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0;
    endtask

    task automatic to_next_cycle();
        @(posedge Clk);
        #1;
    endtask

    function automatic vec_t mk(
        input logic pwe, input logic [4:0] pwa, input logic [31:0] pwd,
        input logic mcv, input logic [4:0] mca, input logic [31:0] mcd,
        input logic iv, input logic [4:0] ird,
        input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
        input logic e_rw, input logic [4:0] e_wa, input logic [31:0] e_wd,
        input logic e_rdy, input logic e_stall);
        vec_t v;
        v.pwe = pwe; v.pwa = pwa; v.pwd = pwd;
        v.mcv = mcv; v.mca = mca; v.mcd = mcd;
        v.iv = iv; v.ird = ird;
        v.rs1 = rs1; v.rs2 = rs2; v.rd = rd;
        v.e_rw = e_rw; v.e_wa = e_wa; v.e_wd = e_wd;
        v.e_rdy = e_rdy; v.e_stall = e_stall;
        return v;
    endfunction

    task automatic pipe_write(input logic [4:0] a, input logic [31:0] d);
        wb_req_t e;
        pipe_we = 1; pipe_waddr = a; pipe_wdata = d;
        e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    initial begin
        // Pipeline write / multi-cycle ordering
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,     0, 0, 0, 0, 0,  0, 0, 0,     1, 0));
        vecs.push_back(mk(1, 5, 32'h1111_0005, 1, 7, 32'hAA, 0, 0, 0, 0, 0,
                          1, 5, 32'h1111_0005, 1, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,     0, 0, 0, 0, 0,  1, 7, 32'hAA, 1, 0));
        vecs.push_back(mk(1, 0, 32'hDEAD,     0, 0, 0,     0, 0, 0, 0, 0,  0, 0, 0,     1, 0));
        vecs.push_back(mk(1, 10, 32'hA0A,     1, 11, 32'hB1, 0, 0, 0, 0, 0, 1, 10, 32'hA0A, 1, 0));
        vecs.push_back(mk(1, 12, 32'hC0C,     1, 13, 32'hB2, 0, 0, 0, 0, 0, 1, 12, 32'hC0C, 1, 0));
        vecs.push_back(mk(1, 14, 32'hE0E,     1, 15, 32'hB3, 0, 0, 0, 0, 0, 1, 14, 32'hE0E, 0, 0));
        vecs.push_back(mk(0, 0, 0,            1, 15, 32'hB3, 0, 0, 0, 0, 0, 1, 11, 32'hB1, 0, 0));
        vecs.push_back(mk(0, 0, 0,            1, 15, 32'hB3, 0, 0, 0, 0, 0, 1, 13, 32'hB2, 1, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,     0, 0, 0, 0, 0,  1, 15, 32'hB3, 1, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,     0, 0, 0, 0, 0,  0, 0, 0,     1, 0));
        // Scoreboard: stall on x9 until after its write
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,     1, 9, 9, 0, 0,  0, 0, 0,     1, 0));
        vecs.push_back(mk(0, 0, 0,            1, 9, 32'hC9, 0, 0, 9, 0, 0, 0, 0, 0,     1, 1));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,     0, 0, 9, 0, 0,  1, 9, 32'hC9, 1, 1));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,     0, 0, 9, 0, 0,  0, 0, 0,     1, 0));
        // Same-cycle set and clear of x3: set wins
        vecs.push_back(mk(0, 0, 0,            1, 3, 32'hD3, 1, 3, 0, 0, 0,  0, 0, 0,     1, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,     1, 3, 0, 3, 0,  1, 3, 32'hD3, 1, 1));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,     0, 0, 0, 3, 0,  0, 0, 0,     1, 1));
        // Issue to x0 never marks busy
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,     1, 0, 0, 0, 0,  0, 0, 0,     1, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,     0, 0, 0, 0, 0,  0, 0, 0,     1, 0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,     0, 0, 0, 0, 3,  0, 0, 0,     1, 1));

        // Reset state with live requests on the inputs
        idle_inputs();
        Reset = 1;
        pipe_we = 1; pipe_waddr = 5; pipe_wdata = 32'h55; mc_valid = 1; mc_waddr = 6;
        to_next_cycle();
        @(negedge Clk);
        check("reset_regwrite", 32'(RegWrite), 0);
        check("reset_mc_ready", 32'(mc_ready), 0);
        check("reset_stall", 32'(stall), 0);
        check("reset_pipe_hold", 32'(pipe_hold), 0);
        to_next_cycle();
        Reset = 0;

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            pipe_we = v.pwe; pipe_waddr = v.pwa; pipe_wdata = v.pwd;
            mc_valid = v.mcv; mc_waddr = v.mca; mc_wdata = v.mcd;
            issue_valid = v.iv; issue_rd = v.ird;
            id_rs1 = v.rs1; id_rs2 = v.rs2; id_rd = v.rd;
            if (v.e_rw) begin
                wb_req_t e;
                e.addr = v.e_wa; e.data = v.e_wd;
                exp_q.push_back(e);
            end
            @(negedge Clk);
            check($sformatf("v%0d_regwrite", i), 32'(RegWrite), 32'(v.e_rw));
            check($sformatf("v%0d_mc_ready", i), 32'(mc_ready), 32'(v.e_rdy));
            check($sformatf("v%0d_stall", i), 32'(stall), 32'(v.e_stall));
            check($sformatf("v%0d_pipe_hold", i), 32'(pipe_hold), 0);
            to_next_cycle();
        end

        // Mid-operation reset with FIFO full and busy bits set
        idle_inputs();
        pipe_write(1, 32'h101);
        mc_valid = 1; mc_waddr = 20; mc_wdata = 32'h2020; issue_valid = 1; issue_rd = 20;
        to_next_cycle();
        pipe_write(2, 32'h102);
        mc_waddr = 21; mc_wdata = 32'h2121; issue_rd = 21;
        @(negedge Clk);
        check("fill_mc_ready", 32'(mc_ready), 1);
        to_next_cycle();
        idle_inputs();
        Reset = 1;
        pipe_we = 1; pipe_waddr = 4; pipe_wdata = 32'h104; mc_valid = 1; mc_waddr = 22;
        id_rs1 = 20; id_rs2 = 21; id_rd = 3;
        @(negedge Clk);
        check("midrst_regwrite", 32'(RegWrite), 0);
        check("midrst_mc_ready", 32'(mc_ready), 0);
        check("midrst_stall", 32'(stall), 0);
        to_next_cycle();
        Reset = 0;
        pipe_we = 0; mc_valid = 0;
        @(negedge Clk);
        check("postrst_regwrite", 32'(RegWrite), 0);
        check("postrst_stall", 32'(stall), 0);
        check("postrst_mc_ready", 32'(mc_ready), 1);
        to_next_cycle();
        @(negedge Clk);
        check("postrst_regwrite2", 32'(RegWrite), 0);
        to_next_cycle();
        idle_inputs();

`ifdef WB_STARVE_GUARD_EN
        // One pending result starved by a continuous pipeline writer
        begin
            wb_req_t e;
            pipe_write(1, 32'h200);
            mc_valid = 1; mc_waddr = 7; mc_wdata = 32'h77;
            @(negedge Clk);
            check("starve_p0_hold", 32'(pipe_hold), 0);
            to_next_cycle();
            mc_valid = 0;
            for (int k = 1; k <= 4; k++) begin
                pipe_write(5'(1 + k), 32'h200 + 32'(k));
                @(negedge Clk);
                check($sformatf("starve_p%0d_hold", k), 32'(pipe_hold), 0);
                to_next_cycle();
            end
            pipe_we = 1; pipe_waddr = 6; pipe_wdata = 32'h2FF;
            e.addr = 7; e.data = 32'h77;
            exp_q.push_back(e);
            @(negedge Clk);
            check("starve_p5_hold", 32'(pipe_hold), 1);
            check("starve_p5_waddr", 32'(waddr), 7);
            to_next_cycle();
            idle_inputs();
            @(negedge Clk);
            check("starve_after_hold", 32'(pipe_hold), 0);
            check("starve_after_rw", 32'(RegWrite), 0);
            to_next_cycle();
        end
`endif

        check("expected_writes_drained", 32'(exp_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
